booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
- Iterative radix-4 Booth multiplier with a valid/ready handshake on input and output.
- Generalises the combinational 16x16 Booth partial-product stage to:
  - a parametrised operand width,
  - a selectable number of Booth digits retired per cycle,
  - a per-transaction signed/unsigned mode.
- Accumulates partial products internally and returns the full 2*WIDTH product.
- Sits as a compact, area-oriented alternative to the fully parallel multiplier tree in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand width; even, >= 4.
- DIGITS_PER_CYCLE, 1, radix-4 Booth digits processed per clock; 1 <= value <= WIDTH/2+1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- xin  input  WIDTH  multiplicand.
- yin  input  WIDTH  multiplier (Booth-recoded operand).
- in_signed  input  1  1: both operands two's complement; 0: both unsigned; sampled at accept.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- prod  output  2*WIDTH  product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Derived constants:
  - N = WIDTH/2+1 digits; this covers the extra digit needed for unsigned operands.
  - C = ceil(N/DIGITS_PER_CYCLE) compute cycles.
  - YE = 2*DIGITS_PER_CYCLE*C bits.
- Operand capture on accept:
  - xin is extended to WIDTH+2 bits; yin is extended to YE bits.
  - Extension is sign extension if in_signed=1, zero extension otherwise.
  - An implicit 0 is appended below yin bit 0.
  - Digits beyond N recode to 0 by construction; no special casing.
- Digit i is recoded from the triplet {y[2i+1], y[2i], y[2i-1]}:
  - 000/111 -> 0
  - 001/010 -> +X
  - 011 -> +2X
  - 100 -> -2X
  - 101/110 -> -X
  - Negation is invert plus a +1 injected into the accumulator at the digit's LSB weight.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture the extended operands and the mode, clear the accumulator, clear the digit counter, go to CALC.
  - CALC: each cycle adds DIGITS_PER_CYCLE partial products, digit j shifted by 2j, into an accumulator of 2*WIDTH+4 bits; then increment the counter. After the C-th CALC cycle, load prod with accumulator[2*WIDTH-1:0] and go to DONE.
  - DONE: out_valid=1 and prod is held stable. On out_ready, go to IDLE.
- No overlap: in_ready=0 in CALC and DONE, so at most one transaction is in flight.
- Latency: accept at edge k gives out_valid high after edge k+C.
  - WIDTH=16, D=1: C=9.
  - WIDTH=16, D=3: C=3.
- Throughput: at most one product per C+2 cycles with out_ready tied high (C compute cycles + DONE cycle + IDLE accept cycle).
- Arithmetic: all accumulation is modulo 2^(2*WIDTH+4). The truncated 2*WIDTH result is exact for every signed and unsigned operand pair.
- Stability: inputs are ignored outside the accept cycle. Changes to xin, yin or in_signed during CALC/DONE have no effect.
- Reset, asynchronous and taking effect at any time including mid-CALC or in DONE:
  - State -> IDLE; in-flight transaction discarded.
  - prod=0, out_valid=0, busy=0, accumulator and counter cleared.
  - in_ready=1 while rst_n is deasserted and afterwards.
- out_ready held high while not in DONE has no effect.
- in_valid held high continuously: the next operand pair is accepted in the first IDLE cycle after the DONE handshake.

Decomposition:
- Package mul_pkg:
  - Booth digit encoding type: 3-bit {neg, two, one}.
  - Encoding constants for 0, +X, +2X, -X, -2X.
  - FSM state enum: IDLE, CALC, DONE.
  - Function computing C from WIDTH and DIGITS_PER_CYCLE.
- Sub-module booth_pp_gen (parametrised on WIDTH):
  - Takes the extended X and one triplet.
  - Outputs a WIDTH+3-bit sign-extended partial product and the neg bit.
  - Instantiated DIGITS_PER_CYCLE times in a generate loop.
- Top level holds the FSM, counter, shift registers and accumulator.

Test Plan:
- Signed corner, WIDTH=16, D=1: x=0x8000, y=0x8000, in_signed=1 -> prod=0x40000000; out_valid exactly 9 cycles after accept.
- Unsigned max: x=0xFFFF, y=0xFFFF, in_signed=0 -> prod=0xFFFE0001.
- Mixed sign and zero:
  - signed x=0xFFFF(-1), y=0x0003 -> prod=0xFFFFFFFD.
  - x=0x1234, y=0 -> prod=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid high and new operands driven -> prod stable, in_ready=0 throughout; next accept only after the out_ready handshake.
- Reset mid-CALC: deassert rst_n at CALC cycle 4 -> prod=0, out_valid=0, in_ready=1 immediately; the following transaction (x=7, y=6) -> prod=42.
- Parameter sweep with constrained-random operands and mode against a behavioural reference model, for (WIDTH, D) in {(16,1), (16,3), (8,5), (32,2)} -> all products match; latency equals C.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package mul_pkg;

    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } booth_digit_t;

    localparam booth_digit_t BOOTH_ZERO = 3'b000;
    localparam booth_digit_t BOOTH_POS1 = 3'b001;
    localparam booth_digit_t BOOTH_POS2 = 3'b010;
    localparam booth_digit_t BOOTH_NEG1 = 3'b101;
    localparam booth_digit_t BOOTH_NEG2 = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra digit beyond WIDTH/2 so zero-extended unsigned operands recode exactly.
    function automatic int calc_cycles(input int width, input int digits);
        return (width / 2 + 1 + digits - 1) / digits;
    endfunction

    function automatic booth_digit_t booth_recode(input logic [2:0] triplet);
        booth_digit_t digit;
        case (triplet)
            3'b001, 3'b010: digit = BOOTH_POS1;
            3'b011:         digit = BOOTH_POS2;
            3'b100:         digit = BOOTH_NEG2;
            3'b101, 3'b110: digit = BOOTH_NEG1;
            default:        digit = BOOTH_ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator for one recoded digit.
module booth_pp_gen
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH+1:0] x_i,
    input  logic [2:0]       triplet_i,
    output logic [WIDTH+2:0] pp_o,
    output logic             neg_o
);

    booth_digit_t      digit;
    logic [WIDTH+2:0]  mag;

    // Negative digits are inverted here; the +1 is added by the accumulator.
    always_comb begin
        digit = booth_recode(triplet_i);
        mag   = '0;
        if (digit.one) begin
            mag = {x_i[WIDTH+1], x_i};
        end else if (digit.two) begin
            mag = {x_i, 1'b0};
        end
        pp_o  = digit.neg ? ~mag : mag;
        neg_o = digit.neg;
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier retiring DIGITS_PER_CYCLE digits per clock.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int DIGITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     xin,
    input  logic [WIDTH-1:0]     yin,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy
);

    localparam int D   = DIGITS_PER_CYCLE;
    localparam int C   = calc_cycles(WIDTH, D);
    localparam int YE  = 2 * D * C;
    localparam int AW  = 2 * WIDTH + 4;
    localparam int XW  = WIDTH + 2;
    localparam int PPW = WIDTH + 3;
    localparam int CW  = $clog2(C + 1);
    localparam logic [CW-1:0] LAST = CW'(C - 1);

    state_t              state_q, state_d;
    logic [XW-1:0]       xOp_q, xOp_d;
    logic [YE:0]         yOp_q, yOp_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*WIDTH-1:0]  prod_q, prod_d;

    logic [XW-1:0]       xExt;
    logic [YE:0]         yExt;
    logic [PPW-1:0]      pp [D];
    logic [D-1:0]        ppNeg;
    logic [AW-1:0]       ppExt;
    logic [AW-1:0]       accSum;
    logic [31:0]         shiftBase;

    // The multiplier register holds an implicit zero below bit 0 for the first triplet.
    always_comb begin
        xExt = in_signed ? {{2{xin[WIDTH-1]}}, xin} : {2'b00, xin};
        yExt = {{(YE-WIDTH){in_signed & yin[WIDTH-1]}}, yin, 1'b0};
    end

    for (genvar j = 0; j < D; j++) begin : g_pp
        booth_pp_gen #(
            .WIDTH (WIDTH)
        ) u_pp (
            .x_i       (xOp_q),
            .triplet_i (yOp_q[2*j+2:2*j]),
            .pp_o      (pp[j]),
            .neg_o     (ppNeg[j])
        );
    end

    // Digit j of cycle k lands at bit weight 2*(k*D + j).
    always_comb begin
        accSum    = acc_q;
        ppExt     = '0;
        shiftBase = 32'(count_q) * 32'(2 * D);
        for (int j = 0; j < D; j++) begin
            ppExt  = {{(AW-PPW){pp[j][PPW-1]}}, pp[j]};
            accSum = accSum + (ppExt << (shiftBase + 32'(2 * j)))
                            + (AW'(ppNeg[j]) << (shiftBase + 32'(2 * j)));
        end
    end

    always_comb begin
        state_d   = state_q;
        xOp_d     = xOp_q;
        yOp_d     = yOp_q;
        acc_d     = acc_q;
        count_d   = count_q;
        prod_d    = prod_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    xOp_d   = xExt;
                    yOp_d   = yExt;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = accSum;
                yOp_d   = yOp_q >> (2 * D);
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    prod_d  = accSum[2*WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xOp_q   <= '0;
            yOp_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            xOp_q   <= xOp_d;
            yOp_q   <= yOp_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            prod_q  <= prod_d;
        end
    end

    assign prod = prod_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench: directed vectors on a 16x16 D=1 instance plus randomized sweeps of other configurations.
module tb_booth_mul_seq;

    typedef struct {
        logic [63:0] exp;
        longint      acceptCyc;
    } sb_t;

    int     checks = 0;
    int     failures = 0;
    int     sweepDoneCount = 0;
    longint cyc = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic        rstSweep;
    logic        inValid;
    logic        inReady;
    logic [15:0] xin;
    logic [15:0] yin;
    logic        inSigned;
    logic        outValid;
    logic        outReady;
    logic [31:0] prod;
    logic        busy;

    sb_t  sbQ[$];
    logic prevValid = 1'b0;

    booth_mul_seq #(
        .WIDTH            (16),
        .DIGITS_PER_CYCLE (1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .xin       (xin),
        .yin       (yin),
        .in_signed (inSigned),
        .out_valid (outValid),
        .out_ready (outReady),
        .prod      (prod),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Behavioural reference: extend to 64 bits, multiply, keep 2*w bits.
    function automatic logic [63:0] refMul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, input int w);
        logic [63:0] xe;
        logic [63:0] ye;
        logic [63:0] p;
        xe = {32'b0, x};
        ye = {32'b0, y};
        if (s && x[w-1]) xe = xe | (~64'b0 << w);
        if (s && y[w-1]) ye = ye | (~64'b0 << w);
        p = xe * ye;
        if (w < 32) p = p & ((64'b1 << (2 * w)) - 64'b1);
        return p;
    endfunction

    // Main monitor: latency on the rising edge of out_valid, product on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            if (outValid && !prevValid) begin
                if (sbQ.size() == 0) checkOutput("unexpected_valid", 64'd1, 64'd0);
                else checkOutput("latency", cyc - sbQ[0].acceptCyc, 64'd9);
            end
            if (outValid && outReady && sbQ.size() > 0) begin
                checkOutput("product", {32'b0, prod}, sbQ[0].exp);
                void'(sbQ.pop_front());
            end
            prevValid = outValid;
        end
    end

    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                                 input logic s, input logic [31:0] exp);
        bit accepted;
        accepted = 0;
        @(posedge clk); #1;
        xin = x; yin = y; inSigned = s; inValid = 1'b1;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            if (inReady) begin
                accepted = 1;
                sbQ.push_back('{exp: {32'b0, exp}, acceptCyc: cyc + 1});
            end
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 500 && sbQ.size() != 0; i++) @(negedge clk);
        if (sbQ.size() != 0) begin
            checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
            sbQ.delete();
        end
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; rstSweep = 1'b0;
        inValid = 1'b0; outReady = 1'b1;
        xin = '0; yin = '0; inSigned = 1'b0;
        #12;
        checkOutput("reset_in_ready", {63'b0, inReady}, 64'd1);
        checkOutput("reset_out_valid", {63'b0, outValid}, 64'd0);
        checkOutput("reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("reset_prod", {32'b0, prod}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; rstSweep = 1'b1;

        applyStimulus(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        applyStimulus(16'hFFFF, 16'h0003, 1'b1, 32'hFFFF_FFFD);
        applyStimulus(16'h1234, 16'h0000, 1'b0, 32'h0000_0000);
        applyStimulus(16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
        applyStimulus(16'h1234, 16'h5678, 1'b0, 32'h0626_0060);
        applyStimulus(16'hFFFF, 16'h0002, 1'b0, 32'h0001_FFFE);
        waitDrain();

        // Backpressure: product held while operands churn and in_valid stays high.
        @(posedge clk); #1;
        outReady = 1'b0;
        applyStimulus(16'd3, 16'd5, 1'b0, 32'd15);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = outValid;
        end
        if (!seen) checkOutput("bp_valid_timeout", 64'd0, 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            xin = 16'h1000 + 16'(k); yin = 16'h0F0F; inSigned = k[0]; inValid = 1'b1;
            @(negedge clk);
            checkOutput("bp_prod", {32'b0, prod}, 64'd15);
            checkOutput("bp_in_ready", {63'b0, inReady}, 64'd0);
            checkOutput("bp_out_valid", {63'b0, outValid}, 64'd1);
        end
        @(posedge clk); #1;
        xin = 16'h1111; yin = 16'h0002; inSigned = 1'b0; outReady = 1'b1;
        @(negedge clk);
        checkOutput("bp_hs_in_ready", {63'b0, inReady}, 64'd0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (inReady) begin
                seen = 1;
                sbQ.push_back('{exp: 64'h2222, acceptCyc: cyc + 1});
            end
        end
        if (!seen) checkOutput("bp_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        inValid = 1'b0;
        waitDrain();

        // Asynchronous reset in the fourth CALC cycle discards the transaction.
        applyStimulus(16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_prod", {32'b0, prod}, 64'd0);
        checkOutput("rst_out_valid", {63'b0, outValid}, 64'd0);
        checkOutput("rst_in_ready", {63'b0, inReady}, 64'd1);
        checkOutput("rst_busy", {63'b0, busy}, 64'd0);
        sbQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'd7, 16'd6, 1'b0, 32'd42);
        waitDrain();

        for (int i = 0; i < 20000 && sweepDoneCount < 3; i++) @(negedge clk);
        if (sweepDoneCount < 3) checkOutput("sweep_timeout", 64'(sweepDoneCount), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    for (genvar g = 1; g < 4; g++) begin : g_sweep
        localparam int W   = (g == 1) ? 16 : (g == 2) ? 8 : 32;
        localparam int D   = (g == 1) ? 3 : (g == 2) ? 5 : 2;
        localparam int LAT = (g == 1) ? 3 : (g == 2) ? 1 : 9;

        logic           sInValid;
        logic           sInReady;
        logic [W-1:0]   sX;
        logic [W-1:0]   sY;
        logic           sSigned;
        logic           sOutValid;
        logic           sOutReady;
        logic [2*W-1:0] sProd;
        logic           sBusy;
        sb_t            q[$];
        logic           prevV = 1'b0;

        booth_mul_seq #(
            .WIDTH            (W),
            .DIGITS_PER_CYCLE (D)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rstSweep),
            .in_valid  (sInValid),
            .in_ready  (sInReady),
            .xin       (sX),
            .yin       (sY),
            .in_signed (sSigned),
            .out_valid (sOutValid),
            .out_ready (sOutReady),
            .prod      (sProd),
            .busy      (sBusy)
        );

        always @(negedge clk) begin
            if (!rstSweep) begin
                prevV = 1'b0;
            end else begin
                if (sOutValid && !prevV) begin
                    if (q.size() == 0) checkOutput($sformatf("w%0d_d%0d_unexpected", W, D), 64'd1, 64'd0);
                    else checkOutput($sformatf("w%0d_d%0d_latency", W, D), cyc - q[0].acceptCyc, 64'(LAT));
                end
                if (sOutValid && sOutReady && q.size() > 0) begin
                    checkOutput($sformatf("w%0d_d%0d_product", W, D), 64'(sProd), q[0].exp);
                    void'(q.pop_front());
                end
                prevV = sOutValid;
            end
        end

        initial begin
            sOutReady = 1'b1;
            forever begin
                @(posedge clk); #1;
                sOutReady = ($urandom_range(0, 3) != 0);
            end
        end

        initial begin
            bit accepted;
            sInValid = 1'b0; sX = '0; sY = '0; sSigned = 1'b0;
            wait (rstSweep === 1'b1);
            for (int n = 0; n < 24; n++) begin
                @(posedge clk); #1;
                if (n == 0) begin
                    sX = {1'b1, {(W-1){1'b0}}}; sY = sX; sSigned = 1'b1;
                end else if (n == 1) begin
                    sX = '1; sY = '1; sSigned = 1'b0;
                end else begin
                    sX = W'($urandom); sY = W'($urandom); sSigned = 1'($urandom_range(0, 1));
                end
                sInValid = 1'b1;
                accepted = 0;
                for (int i = 0; i < 200 && !accepted; i++) begin
                    @(negedge clk);
                    if (sInReady) begin
                        accepted = 1;
                        q.push_back('{exp: refMul(32'(sX), 32'(sY), sSigned, W), acceptCyc: cyc + 1});
                    end
                end
                if (!accepted) checkOutput($sformatf("w%0d_d%0d_accept_timeout", W, D), 64'd0, 64'd1);
                @(posedge clk); #1;
                sInValid = 1'b0;
            end
            for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
            if (q.size() != 0) checkOutput($sformatf("w%0d_d%0d_drain_timeout", W, D), 64'(q.size()), 64'd0);
            sweepDoneCount++;
        end
    end

endmodule
